svreal_accum_dump: RTL and testbench

- Streaming accumulate-and-dump stage for svreal fixed-point values. Sits directly downstream of the fixed-point multiply stage and consumes its product (default 18-bit, exponent -10).
- Aligns each accepted sample to the output format and sums N_SAMPLES of them with saturation.
- Emits the sum, the sample count and a sticky saturation flag through a valid/ready handshake.
- Used for windowed averaging and integration of multiplier outputs in synthesizable svreal datapaths.

---
 rtl/svreal_accum_dump_if.sv | 29 ++
 rtl/svreal_accum_dump.sv | 110 +++++++++++
 tb/tb_svreal_accum_dump.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svreal_accum_dump_if.sv
// Stream bundle for the svreal accumulate-and-dump stage: sample input side plus
// result output side, each with its own valid/ready pair.
interface svreal_accum_dump_if #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 24,
  parameter int N_SAMPLES = 8
);
  localparam int CW = $clog2(N_SAMPLES + 1);

  logic signed [IN_WIDTH-1:0]  in_value;
  logic                        in_valid;
  logic                        in_ready;
  logic                        flush;
  logic signed [OUT_WIDTH-1:0] out_value;
  logic [CW-1:0]               out_count;
  logic                        out_sat;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_value, in_valid, flush, out_ready,
    input  in_ready, out_value, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_value, in_valid, flush, out_ready,
    output in_ready, out_value, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/svreal_accum_dump.sv
// Accumulate-and-dump for svreal fixed-point samples: align each sample to the
// output exponent, sum N_SAMPLES with saturation, emit sum/count/sat via valid/ready.
module svreal_accum_dump #(
  parameter int IN_WIDTH  = 18,
  parameter int IN_EXP    = -10,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_EXP   = -10,
  parameter int N_SAMPLES = 8
) (
  input logic             clk,
  input logic             rst_n,
  svreal_accum_dump_if.slave bus
);
  localparam int CW    = $clog2(N_SAMPLES + 1);
  localparam int SHIFT = IN_EXP - OUT_EXP;
  localparam int LSH   = (SHIFT > 0) ? SHIFT : 0;
  localparam int RSH   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int AW    = ((IN_WIDTH + LSH > OUT_WIDTH) ? IN_WIDTH + LSH : OUT_WIDTH) + 1;
  localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Returns {overflow, value}; right shifts are arithmetic so they floor toward -inf.
  function automatic logic [OUT_WIDTH:0] align_sat(input logic signed [IN_WIDTH-1:0] x);
    logic signed [AW-1:0]    w;
    logic [AW-OUT_WIDTH:0]   top;
    w   = {{(AW-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    w   = (w <<< LSH) >>> RSH;
    top = w[AW-1:OUT_WIDTH-1];
    if ((&top) || !(|top)) return {1'b0, w[OUT_WIDTH-1:0]};
    return {1'b1, (w[AW-1] ? OMIN : OMAX)};
  endfunction

  function automatic logic [OUT_WIDTH:0] add_sat(input logic signed [OUT_WIDTH-1:0] a,
                                                 input logic signed [OUT_WIDTH-1:0] b);
    logic signed [OUT_WIDTH:0] s;
    s = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
    if (s[OUT_WIDTH] == s[OUT_WIDTH-1]) return {1'b0, s[OUT_WIDTH-1:0]};
    return {1'b1, (s[OUT_WIDTH] ? OMIN : OMAX)};
  endfunction

  logic signed [OUT_WIDTH-1:0] acc_p0, acc_nxt, aligned, sum_sat;
  logic [CW-1:0]               cnt_p0, cnt_nxt;
  logic                        sat_p0, sat_nxt, al_ovf, sum_ovf;
  logic signed [OUT_WIDTH-1:0] value_p1;
  logic [CW-1:0]               count_p1;
  logic                        sat_p1, vld_p1;
  logic                        in_ready, accept, dump, out_hs;

  assign in_ready = !vld_p1 || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = vld_p1 && bus.out_ready;

  assign {al_ovf, aligned}  = align_sat(bus.in_value);
  assign {sum_ovf, sum_sat} = add_sat(acc_p0, aligned);

  always_comb begin
    acc_nxt = acc_p0;
    cnt_nxt = cnt_p0;
    sat_nxt = sat_p0;
    if (accept) begin
      acc_nxt = sum_sat;
      cnt_nxt = cnt_p0 + CW'(1);
      sat_nxt = sat_p0 | al_ovf | sum_ovf;
    end
  end

  // cnt_nxt is nonzero exactly when a partial window exists or a sample lands this cycle
  assign dump = (accept && (cnt_nxt == CW'(N_SAMPLES))) ||
                (bus.flush && in_ready && (cnt_nxt != '0));

  // Stage p0: running window sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      sat_p0 <= 1'b0;
    end else if (dump) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      sat_p0 <= 1'b0;
    end else begin
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_nxt;
      sat_p0 <= sat_nxt;
    end
  end

  // Stage p1: held result, only reloaded when the consumer side is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_p1 <= '0;
      count_p1 <= '0;
      sat_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (dump) begin
      value_p1 <= acc_nxt;
      count_p1 <= cnt_nxt;
      sat_p1   <= sat_nxt;
      vld_p1   <= 1'b1;
    end else if (out_hs) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_value = value_p1;
  assign bus.out_count = count_p1;
  assign bus.out_sat   = sat_p1;
  assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_svreal_accum_dump.sv
// Bench for svreal_accum_dump: four differently-configured lanes driven by directed
// and random stimulus, checked every cycle against a window-level reference model.
module tb_svreal_accum_dump;
  localparam int NL = 4;

  function automatic int ow_of(int g);
    case (g)
      0, 1:    return 24;
      2:       return 20;
      default: return 16;
    endcase
  endfunction
  function automatic int oe_of(int g);
    case (g)
      1:       return -8;
      3:       return -12;
      default: return -10;
    endcase
  endfunction
  function automatic int n_of(int g);
    case (g)
      1:       return 4;
      3:       return 3;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [17:0] ival [NL];
  logic ivld [NL], fl [NL], ordy [NL];
  logic irdy [NL], dvld [NL], dsat [NL];
  longint dval [NL];
  int     dcnt [NL];

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int OW = ow_of(g);
    localparam int OE = oe_of(g);
    localparam int NS = n_of(g);
    svreal_accum_dump_if #(.IN_WIDTH(18), .OUT_WIDTH(OW), .N_SAMPLES(NS)) bus ();
    svreal_accum_dump #(.IN_WIDTH(18), .IN_EXP(-10), .OUT_WIDTH(OW), .OUT_EXP(OE),
                        .N_SAMPLES(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.in_value  = ival[g];
    assign bus.in_valid  = ivld[g];
    assign bus.flush     = fl[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g] = bus.in_ready;
    assign dvld[g] = bus.out_valid;
    assign dsat[g] = bus.out_sat;
    assign dval[g] = longint'(bus.out_value);
    assign dcnt[g] = int'(bus.out_count);
  end

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value * 2^shift with floor, clamped to the output range.
  function automatic longint model_align(input longint x, input int sh, input int ow,
                                         output bit s);
    longint v, d, hi, lo;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (sh >= 0) v = x * (longint'(1) << sh);
    else begin
      d = longint'(1) << (-sh);
      v = (x >= 0) ? x / d : -((-x + d - 1) / d);
    end
    s = 1'b0;
    if (v > hi) begin v = hi; s = 1'b1; end
    if (v < lo) begin v = lo; s = 1'b1; end
    return v;
  endfunction

  bit     ev [NL];
  longint ex_val [NL];
  int     ex_cnt [NL];
  bit     ex_sat [NL];
  longint win [NL][16];
  int     wn [NL];

  task automatic window_result(input int g);
    longint a, sum, hi, lo;
    bit s, st;
    hi = (longint'(1) << (ow_of(g) - 1)) - 1;
    lo = -hi - 1;
    sum = 0;
    st = 1'b0;
    for (int i = 0; i < wn[g]; i++) begin
      a = model_align(win[g][i], -10 - oe_of(g), ow_of(g), s);
      st |= s;
      sum += a;
      if (sum > hi) begin sum = hi; st = 1'b1; end
      if (sum < lo) begin sum = lo; st = 1'b1; end
    end
    ex_val[g] = sum;
    ex_sat[g] = st;
    ex_cnt[g] = wn[g];
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int g = 0; g < NL; g++) begin
      if (!rst_n) begin
        ev[g] = 1'b0;
        wn[g] = 0;
      end else begin
        bit rdy, acc, dmp;
        rdy = !ev[g] || ordy[g];
        acc = ivld[g] && rdy;
        if (acc) begin
          win[g][wn[g]] = longint'(ival[g]);
          wn[g]++;
        end
        dmp = (acc && wn[g] == n_of(g)) || (fl[g] && rdy && wn[g] > 0);
        if (dmp) begin
          window_result(g);
          ev[g] = 1'b1;
          wn[g] = 0;
        end else if (ev[g] && ordy[g]) begin
          ev[g] = 1'b0;
        end
      end
    end
  end

  int nres [NL];
  initial for (int g = 0; g < NL; g++) nres[g] = 0;

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("L%0d in_ready", g), longint'(irdy[g]), longint'(!ev[g] || ordy[g]));
      chk($sformatf("L%0d out_valid", g), longint'(dvld[g]), longint'(ev[g]));
      if (ev[g]) begin
        chk($sformatf("L%0d out_value", g), dval[g], ex_val[g]);
        chk($sformatf("L%0d out_count", g), longint'(dcnt[g]), longint'(ex_cnt[g]));
        chk($sformatf("L%0d out_sat", g), longint'(dsat[g]), longint'(ex_sat[g]));
      end
      if (dvld[g] && ordy[g]) nres[g]++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < NL; g++) begin
      ivld[g] = 1'b0;
      fl[g]   = 1'b0;
      ival[g] = '0;
      ordy[g] = 1'b1;
    end
  endtask

  task automatic burst(input int g, input int v, input int n);
    ivld[g] = 1'b1;
    ival[g] = 18'(v);
    repeat (n) cyc();
    ivld[g] = 1'b0;
  endtask

  task automatic pin(input int g, input string name, input longint v, input longint c,
                     input longint s);
    chk({name, " valid"}, longint'(dvld[g]), 1);
    chk({name, " value"}, dval[g], v);
    chk({name, " count"}, longint'(dcnt[g]), c);
    chk({name, " sat"}, longint'(dsat[g]), s);
    chk({name, " model"}, ex_val[g], v);
  endtask

  initial begin
    int n0, r;
    idle_all();
    rst_n = 1'b0;
    repeat (3) cyc();
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("L%0d reset valid", g), longint'(dvld[g]), 0);
      chk($sformatf("L%0d reset value", g), dval[g], 0);
      chk($sformatf("L%0d reset count", g), longint'(dcnt[g]), 0);
      chk($sformatf("L%0d reset sat", g), longint'(dsat[g]), 0);
    end
    rst_n = 1'b1;
    cyc();
    chk("ready after reset", longint'(irdy[0]), 1);

    burst(0, 1024, 8);
    pin(0, "8x1.0", 8192, 8, 0);
    cyc();
    chk("8x1.0 one-cycle valid", longint'(dvld[0]), 0);

    burst(1, 1024, 2);
    burst(1, -1, 2);
    pin(1, "rshift window", 510, 4, 0);
    cyc();

    burst(2, 131071, 8);
    pin(2, "sat window", 524287, 8, 1);
    cyc();
    burst(2, 1, 8);
    pin(2, "post-sat window", 8, 8, 0);
    cyc();

    ordy[0] = 1'b0;
    ivld[0] = 1'b1;
    ival[0] = 18'(1024);
    repeat (8) cyc();
    ival[0] = 18'(7);
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", longint'(irdy[0]), 0);
      chk("stall value", dval[0], 8192);
      cyc();
    end
    ordy[0] = 1'b1;
    #1;
    chk("release in_ready", longint'(irdy[0]), 1);
    repeat (8) cyc();
    ivld[0] = 1'b0;
    pin(0, "post-stall window", 56, 8, 0);
    cyc();

    burst(0, 100, 3);
    ivld[0] = 1'b1;
    fl[0]   = 1'b1;
    cyc();
    ivld[0] = 1'b0;
    fl[0]   = 1'b0;
    pin(0, "flush window", 400, 4, 0);
    cyc();
    n0 = nres[0];
    fl[0] = 1'b1;
    cyc();
    fl[0] = 1'b0;
    cyc();
    chk("empty flush valid", longint'(dvld[0]), 0);
    chk("empty flush results", longint'(nres[0]), longint'(n0));

    burst(0, 1024, 5);
    rst_n = 1'b0;
    cyc();
    chk("mid-reset valid a", longint'(dvld[0]), 0);
    cyc();
    chk("mid-reset valid b", longint'(dvld[0]), 0);
    rst_n = 1'b1;
    cyc();
    burst(0, 1, 8);
    pin(0, "post-reset window", 8, 8, 0);
    cyc();

    repeat (3000) begin
      for (int g = 0; g < NL; g++) begin
        case ($urandom % 4)
          0:       r = int'($urandom_range(0, 200)) - 100;
          1:       r = 131071;
          2:       r = -131072;
          default: r = int'($urandom % 262144) - 131072;
        endcase
        ival[g] = 18'(r);
        ivld[g] = ($urandom % 4) != 0;
        fl[g]   = ($urandom % 16) == 0;
        ordy[g] = ($urandom % 4) != 0;
      end
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
